// File: rtl/gate_identifier_if.sv
// Control-side bundle for gate_identifier: start request, status and classification result.
// The requester holds the master modport; the identifier holds the slave modport.
interface gate_identifier_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] truth;
    logic [2:0] gate_code;
    logic       match;

    modport master (
        output start,
        input  busy, done, truth, gate_code, match
    );

    modport slave (
        input  start,
        output busy, done, truth, gate_code, match
    );
endinterface

// File: rtl/gate_identifier.sv
// Characterises an unknown 2-input gate by walking {a,b} through 00..11 and sampling y_in
// after a settle delay, then classifying the captured truth table.
module gate_identifier #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_identifier_if.slave        ctrl,
    output logic                    a_out,
    output logic                    b_out,
    input  logic                    y_in
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StClassify} state_t;

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] truth_q, truth_d;
    logic [2:0] code_q, code_d;
    logic       match_q, match_d;
    logic       done_q, done_d;
    logic       a_q, a_d;
    logic       b_q, b_d;

    // truth index is {a,b}, so bit 3 is a=1,b=1 and bit 0 is a=0,b=0
    function automatic logic [2:0] decode(input logic [3:0] t);
        case (t)
            4'b1000: decode = 3'd1;
            4'b1110: decode = 3'd2;
            4'b0011: decode = 3'd3;
            4'b0111: decode = 3'd4;
            4'b0001: decode = 3'd5;
            4'b0110: decode = 3'd6;
            4'b1001: decode = 3'd7;
            default: decode = 3'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        code_d  = code_q;
        match_d = match_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            StIdle: begin
                // the done cycle is spent in StIdle, so a start there must be refused explicitly
                if (ctrl.start && !done_q) begin
                    state_d = StDrive;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    truth_d = 4'd0;
                    code_d  = 3'd0;
                    match_d = 1'b0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                truth_d[idx_q] = y_in;
                cnt_d          = 4'd0;
                if (idx_q == 2'd3) begin
                    state_d = StClassify;
                end else begin
                    idx_d        = idx_q + 2'd1;
                    {a_d, b_d}   = idx_q + 2'd1;
                    state_d      = StDrive;
                end
            end
            StClassify: begin
                code_d  = decode(truth_q);
                match_d = (decode(truth_q) != 3'd0);
                done_d  = 1'b1;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            truth_q <= 4'd0;
            code_q  <= 3'd0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            code_q  <= code_d;
            match_q <= match_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign ctrl.busy      = (state_q != StIdle);
    assign ctrl.done      = done_q;
    assign ctrl.truth     = truth_q;
    assign ctrl.gate_code = code_q;
    assign ctrl.match     = match_q;
    assign a_out          = a_q;
    assign b_out          = b_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier (SETTLE=2): a behavioural gate model drives y_in from
// a_out/b_out, and each task checks latency, truth table and classification.
module tb_gate_identifier;

    localparam int ModeAnd  = 0;
    localparam int ModeXor  = 1;
    localparam int ModeNor  = 2;
    localparam int ModeNotA = 3;
    localparam int ModeOne  = 4;
    localparam int ModeNand = 5;
    localparam int ModeOr   = 6;

    logic clk;
    logic rst;
    logic a_out;
    logic b_out;
    logic y_in;
    logic f;
    int   mode;
    bit   poison;
    bit   win;
    int   checks;
    int   errors;

    gate_identifier_if bus ();

    gate_identifier #(.SETTLE(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .ctrl  (bus),
        .a_out (a_out),
        .b_out (b_out),
        .y_in  (y_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outside the sampling window a poisoned run drives the wrong answer, a 2-state stand-in
    // for X that makes any out-of-window sample visible in the truth table.
    always_comb begin
        case (mode)
            ModeAnd:  f = a_out & b_out;
            ModeXor:  f = a_out ^ b_out;
            ModeNor:  f = ~(a_out | b_out);
            ModeNotA: f = ~a_out;
            ModeOne:  f = 1'b1;
            ModeNand: f = ~(a_out & b_out);
            ModeOr:   f = a_out | b_out;
            default:  f = 1'b0;
        endcase
        y_in = (poison && !win) ? ~f : f;
    end

    // Pulses start and returns the cycle (1 = cycle after the accepting edge) in which
    // done is seen, or -1 if it never arrives. Returns at the negedge of the done cycle.
    task automatic run_char(input int m, output int lat);
        mode      = m;
        lat       = -1;
        bus.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            win = (k <= 12) && ((k - 1) % 3 == 2);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        win = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_out, b_out, bus.busy, bus.done, bus.match} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: a,b,busy,done,match=%b required 00000",
                     {a_out, b_out, bus.busy, bus.done, bus.match});
        end
        checks++;
        if ({bus.truth, bus.gate_code} !== 7'b0) begin
            errors++;
            $display("FAIL reset_result: truth=%b code=%0d required 0000/0",
                     bus.truth, bus.gate_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_and;
        int lat;
        run_char(ModeAnd, lat);
        checks++;
        if (lat !== 14) begin
            errors++;
            $display("FAIL and_latency: got %0d required 14", lat);
        end
        checks++;
        if (bus.truth !== 4'b1000 || bus.gate_code !== 3'd1 || bus.match !== 1'b1) begin
            errors++;
            $display("FAIL and_result: truth=%b code=%0d match=%b required 1000/1/1",
                     bus.truth, bus.gate_code, bus.match);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL and_busy_at_done: got %b required 0", bus.busy);
        end
        // start during the done cycle must be dropped
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: done=%b busy=%b required 0/0", bus.done, bus.busy);
        end
        checks++;
        if (bus.truth !== 4'b1000 || bus.gate_code !== 3'd1 || bus.match !== 1'b1) begin
            errors++;
            $display("FAIL and_hold: truth=%b code=%0d match=%b required 1000/1/1",
                     bus.truth, bus.gate_code, bus.match);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        run_char(ModeXor, lat);
        checks++;
        if (lat !== 14 || bus.truth !== 4'b0110 || bus.gate_code !== 3'd6) begin
            errors++;
            $display("FAIL b2b_xor: lat=%0d truth=%b code=%0d required 14/0110/6",
                     lat, bus.truth, bus.gate_code);
        end
        @(negedge clk);
        run_char(ModeNor, lat);
        checks++;
        if (lat !== 14 || bus.truth !== 4'b0001 || bus.gate_code !== 3'd5) begin
            errors++;
            $display("FAIL b2b_nor: lat=%0d truth=%b code=%0d required 14/0001/5",
                     lat, bus.truth, bus.gate_code);
        end
    endtask

    task automatic test_not_and_const;
        int lat;
        @(negedge clk);
        run_char(ModeNotA, lat);
        checks++;
        if (bus.truth !== 4'b0011 || bus.gate_code !== 3'd3 || bus.match !== 1'b1) begin
            errors++;
            $display("FAIL nota: truth=%b code=%0d match=%b required 0011/3/1",
                     bus.truth, bus.gate_code, bus.match);
        end
        @(negedge clk);
        run_char(ModeOne, lat);
        checks++;
        if (lat !== 14 || bus.truth !== 4'b1111 || bus.gate_code !== 3'd0
            || bus.match !== 1'b0) begin
            errors++;
            $display("FAIL const1: lat=%0d truth=%b code=%0d match=%b required 14/1111/0/0",
                     lat, bus.truth, bus.gate_code, bus.match);
        end
    endtask

    task automatic test_start_spam;
        logic [1:0] exp_ab;
        @(negedge clk);
        mode      = ModeAnd;
        bus.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) bus.start = 1'b0;
            if (k <= 12) begin
                exp_ab = 2'((k - 1) / 3);
                checks++;
                if ({a_out, b_out} !== exp_ab) begin
                    errors++;
                    $display("FAIL spam_ab cycle %0d: got %b required %b",
                             k, {a_out, b_out}, exp_ab);
                end
            end
            checks++;
            if (bus.done !== (k == 14) || bus.busy !== (k <= 13)) begin
                errors++;
                $display("FAIL spam_status cycle %0d: done=%b busy=%b required %b/%b",
                         k, bus.done, bus.busy, k == 14, k <= 13);
            end
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        @(negedge clk);
        mode      = ModeOr;
        bus.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        checks++;
        if ({a_out, b_out} !== 2'b10) begin
            errors++;
            $display("FAIL abort_vector: a,b=%b required 10", {a_out, b_out});
        end
        // reset and start together: reset wins
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({a_out, b_out, bus.busy, bus.done, bus.match, bus.truth, bus.gate_code}
            !== 12'b0) begin
            errors++;
            $display("FAIL abort_outputs: a,b,busy,done,match,truth,code=%b required all 0",
                     {a_out, b_out, bus.busy, bus.done, bus.match, bus.truth, bus.gate_code});
        end
        // first cycle with rst low accepts start; an early done would expose a leftover run
        run_char(ModeNand, lat);
        checks++;
        if (lat !== 14 || bus.truth !== 4'b0111 || bus.gate_code !== 3'd4) begin
            errors++;
            $display("FAIL abort_nand: lat=%0d truth=%b code=%0d required 14/0111/4",
                     lat, bus.truth, bus.gate_code);
        end
    endtask

    task automatic test_glitch;
        int lat;
        @(negedge clk);
        poison = 1'b1;
        run_char(ModeOr, lat);
        poison = 1'b0;
        checks++;
        if (lat !== 14 || bus.truth !== 4'b1110 || bus.gate_code !== 3'd2
            || bus.match !== 1'b1) begin
            errors++;
            $display("FAIL glitch_or: lat=%0d truth=%b code=%0d match=%b required 14/1110/2/1",
                     lat, bus.truth, bus.gate_code, bus.match);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = ModeAnd;
        poison    = 1'b0;
        win       = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_and();
        test_back_to_back();
        test_not_and_const();
        test_start_spam();
        test_reset_abort();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
GATE_IDENTIFIER -- requirements
Module: gate_identifier

Interface
REQ-001 Parameter: SETTLE, default 2, cycles each input vector is held before sampling y_in; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to characterise the gate under test; honoured only when busy=0.
REQ-005 a_out  output  1  stimulus to gate input a.
REQ-006 b_out  output  1  stimulus to gate input b.
REQ-007 y_in  input  1  gate-under-test output; combinational from a_out/b_out, settled within SETTLE cycles.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-009 done  output  1  one-cycle pulse; gate_code/truth/match valid from this cycle.
REQ-010 truth  output  4  captured truth table; truth[i] = y_in sampled with {a_out,b_out} = i.
REQ-011 gate_code  output  3  classification: 0 unknown, 1 AND, 2 OR, 3 NOT(a), 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
REQ-012 match  output  1  high when gate_code != 0.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE, CLASSIFY; 2-bit vector index idx, 4-bit settle counter.
REQ-014 IDLE: a_out=b_out=0, busy=0; start=1 -> DRIVE with idx=0, counter=0, truth cleared to 0, match and gate_code cleared.
REQ-015 DRIVE: {a_out,b_out}=idx; counter increments each cycle; when counter reaches SETTLE-1 -> SAMPLE.
REQ-016 SAMPLE (one cycle, {a_out,b_out} still = idx): truth[idx] <= y_in; idx=3 -> CLASSIFY, else idx+1, counter=0, -> DRIVE.
REQ-017 Each vector occupies exactly SETTLE+1 cycles; vectors applied in order 00, 01, 10, 11.
REQ-018 CLASSIFY (one cycle): decode truth, register gate_code and match, pulse done for exactly one cycle (the cycle after CLASSIFY), return to IDLE.
REQ-019 Decode table (truth[3:0]): 1000 AND, 1110 OR, 0011 NOT(a), 0111 NAND, 0001 NOR, 0110 XOR, 1001 XNOR; all other patterns incl. 0000 and 1111 -> 0, match=0.
REQ-020 Latency: start accepted at edge N -> done high in cycle N + 4*(SETTLE+1) + 2.
REQ-021 start while busy=1 or during the done cycle SHALL be ignored; no queuing.
REQ-022 truth, gate_code, match SHALL hold their values after done until the next accepted start.
REQ-023 a_out/b_out SHALL be registered outputs, glitch-free, changing only on vector boundaries or return to IDLE.
REQ-024 y_in SHALL be ignored outside SAMPLE.

Reset
REQ-025 rst=1 at any edge: FSM -> IDLE; a_out=0, b_out=0, busy=0, done=0, truth=0, gate_code=0, match=0, idx=0, counter=0.
REQ-026 rst mid-characterisation SHALL abort with no done pulse; rst takes priority over start in the same cycle.
REQ-027 First start accepted in the first cycle with rst=0.

Verification
REQ-028 SETTLE=2, y_in=a&b, start pulse -> done exactly 14 cycles later, truth=1000, gate_code=1, match=1.
REQ-029 Back-to-back: y_in=a^b then y_in=~(a|b), each with start after done -> gate_code 6 then 5, truth 0110 then 0001.
REQ-030 y_in=~a -> truth=0011, gate_code=3; y_in tied 1 -> truth=1111, gate_code=0, match=0.
REQ-031 start re-asserted every cycle while busy -> exactly one done per 14 cycles, no early restart, a_out/b_out sequence 00,01,10,11 each held 3 cycles.
REQ-032 rst asserted during vector idx=2 -> next cycle all outputs 0, no done; subsequent start with y_in=~(a&b) -> gate_code=4.
REQ-033 Glitch-check: y_in driven X except during SAMPLE cycles with y_in=a|b -> truth=1110, gate_code=2 (proves sampling window).
